ifm_buf_sched: RTL and testbench

Row-buffer scheduler between cnn_ctrl and the DRAM read DMA for the IFM line buffer. It takes cnn_ctrl row-load requests (req_load/req_row) and manages IFM_BUFFER_CNT ring slots. On a miss it issues one DMA descriptor per row; on a hit it skips the DMA. It answers each request with a one-cycle buf_done pulse, which feeds cnn_ctrl q_ifm_buf_done.

---
 rtl/ifm_buf_sched_pkg.sv | 20 ++
 rtl/ifm_slot_table.sv | 73 +++++++
 rtl/ifm_buf_sched.sv | 174 +++++++++++++++++
 tb/tb_ifm_buf_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifm_buf_sched_pkg.sv
// Shared constants and FSM encoding for the IFM row-buffer scheduler.
// Widths here are the defaults picked up by the scheduler and its slot table.
package ifm_buf_sched_pkg;

   localparam int IFM_W_SIZE     = 12;
   localparam int IFM_W_ADDR     = 32;
   localparam int IFM_W_LEN      = 16;
   localparam int IFM_BUFFER_CNT = 4;
   localparam int IFM_BUFFER     = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_ISSUE,
      ST_WAIT_DMA,
      ST_WAIT_FREE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/ifm_slot_table.sv
// Ring of IFM line-buffer slots: valid/tag per slot, parallel tag lookup,
// fill at wr_ptr and release of the oldest slot at rd_ptr.
module ifm_slot_table
   import ifm_buf_sched_pkg::*;
#(
   parameter int BUF_CNT = IFM_BUFFER_CNT,
   parameter int W_BUF   = IFM_BUFFER,
   parameter int W_SIZE  = IFM_W_SIZE
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               clear,
   input  logic               rel,
   input  logic               fill,
   input  logic [W_SIZE-1:0]  fill_tag,
   input  logic [W_SIZE-1:0]  look_row,
   output logic               hit,
   output logic [W_BUF-1:0]   hit_slot,
   output logic               wr_free,
   output logic [W_BUF-1:0]   wr_ptr,
   output logic [BUF_CNT-1:0] valid
);

   logic [BUF_CNT-1:0] valid_q;
   logic [W_SIZE-1:0]  tag_q [BUF_CNT];
   logic [W_BUF-1:0]   wr_ptr_q;
   logic [W_BUF-1:0]   rd_ptr_q;
   logic               rel_ok;

   assign rel_ok = rel && valid_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         // NOTE: tags are reset too; only a few flops, and it keeps lookups deterministic after reset.
         for (int i = 0; i < BUF_CNT; i++) tag_q[i] <= '0;
      end else if (clear) begin
         valid_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         // NOTE: non-blocking so release and fill on different slots in one cycle both land.
         if (rel_ok) begin
            valid_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q          <= rd_ptr_q + 1'b1;
         end
         if (fill) begin
            valid_q[wr_ptr_q] <= 1'b1;
            tag_q[wr_ptr_q]   <= fill_tag;
            wr_ptr_q          <= wr_ptr_q + 1'b1;
         end
      end
   end

   always_comb begin
      // NOTE: defaults first so the search loop never infers a latch.
      hit      = 1'b0;
      hit_slot = '0;
      for (int i = BUF_CNT - 1; i >= 0; i--) begin
         if (valid_q[i] && (tag_q[i] == look_row)) begin
            hit      = 1'b1;
            hit_slot = W_BUF'(i);
         end
      end
   end

   assign wr_free = !valid_q[wr_ptr_q];
   assign wr_ptr  = wr_ptr_q;
   assign valid   = valid_q;

endmodule

// File: rtl/ifm_buf_sched.sv
// IFM row-buffer scheduler: turns cnn_ctrl row-load requests into slot hits
// or DMA descriptors and answers each with a one-cycle buf_done pulse.
module ifm_buf_sched
   import ifm_buf_sched_pkg::*;
#(
   parameter int W_SIZE  = IFM_W_SIZE,
   parameter int W_ADDR  = IFM_W_ADDR,
   parameter int W_LEN   = IFM_W_LEN,
   parameter int BUF_CNT = IFM_BUFFER_CNT,
   parameter int W_BUF   = IFM_BUFFER
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               i_start,
   input  logic [W_ADDR-1:0]  i_cfg_base,
   input  logic [W_LEN-1:0]   i_cfg_row_bytes,
   input  logic [W_SIZE-1:0]  i_cfg_height,
   input  logic               i_req_load,
   input  logic [W_SIZE-1:0]  i_req_row,
   input  logic               i_release,
   output logic               o_buf_done,
   output logic [W_BUF-1:0]   o_buf_slot,
   output logic               o_busy,
   output logic               o_err,
   output logic               o_dma_req,
   output logic [W_ADDR-1:0]  o_dma_addr,
   output logic [W_LEN-1:0]   o_dma_len,
   output logic [W_BUF-1:0]   o_dma_slot,
   input  logic               i_dma_ack,
   input  logic               i_dma_done,
   output logic [BUF_CNT-1:0] o_resident
);

   localparam int PW = W_SIZE + W_LEN;

   state_t state_q, state_d;

   logic [W_ADDR-1:0] cfg_base_q;
   logic [W_LEN-1:0]  cfg_row_bytes_q;
   logic [W_SIZE-1:0] cfg_height_q;
   logic [W_SIZE-1:0] cur_row_q;
   logic [W_SIZE-1:0] pend_row_q;
   logic              pend_valid_q;
   logic              err_q;
   logic [PW-1:0]     prod_q;
   logic [W_BUF-1:0]  done_slot_q;

   logic              idle, start_ok, take_pend, take_req, pad, fill;
   logic              hit, wr_free;
   logic [W_BUF-1:0]  hit_slot, wr_ptr;

   assign idle      = (state_q == ST_IDLE);
   assign start_ok  = idle && i_start;
   assign take_pend = idle && !i_start && pend_valid_q;
   assign take_req  = idle && !i_start && !pend_valid_q && i_req_load;
   assign pad       = (cur_row_q >= cfg_height_q);
   assign fill      = (state_q == ST_WAIT_DMA) && i_dma_done;

   ifm_slot_table #(
      .BUF_CNT (BUF_CNT),
      .W_BUF   (W_BUF),
      .W_SIZE  (W_SIZE)
   ) u_slot_table (
      .clk      (clk),
      .rstn     (rstn),
      .clear    (start_ok),
      .rel      (i_release),
      .fill     (fill),
      .fill_tag (cur_row_q),
      .look_row (cur_row_q),
      .hit      (hit),
      .hit_slot (hit_slot),
      .wr_free  (wr_free),
      .wr_ptr   (wr_ptr),
      .valid    (o_resident)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      o_buf_done = 1'b0;
      o_dma_req  = 1'b0;
      o_busy     = 1'b1;
      case (state_q)
         ST_IDLE: begin
            o_busy = 1'b0;
            if (take_pend || take_req) state_d = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            if (pad || hit)   state_d = ST_DONE;
            else if (wr_free) state_d = ST_ISSUE;
            else              state_d = ST_WAIT_FREE;
         end
         ST_WAIT_FREE: begin
            if (i_release || wr_free) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            o_dma_req = 1'b1;
            if (i_dma_ack) state_d = ST_WAIT_DMA;
         end
         ST_WAIT_DMA: begin
            if (i_dma_done) state_d = ST_DONE;
         end
         ST_DONE: begin
            o_buf_done = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Config, pending-request latch and sticky overflow flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cfg_base_q      <= '0;
         cfg_row_bytes_q <= '0;
         cfg_height_q    <= '0;
         cur_row_q       <= '0;
         pend_row_q      <= '0;
         pend_valid_q    <= 1'b0;
         err_q           <= 1'b0;
      end else if (start_ok) begin
         cfg_base_q      <= i_cfg_base;
         cfg_row_bytes_q <= i_cfg_row_bytes;
         cfg_height_q    <= i_cfg_height;
         pend_valid_q    <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         if (take_pend) cur_row_q <= pend_row_q;
         else if (take_req) cur_row_q <= i_req_row;

         if (take_pend) begin
            pend_valid_q <= i_req_load;
            if (i_req_load) pend_row_q <= i_req_row;
         end else if (!idle && i_req_load) begin
            if (pend_valid_q) begin
               err_q <= 1'b1;
            end else begin
               pend_valid_q <= 1'b1;
               pend_row_q   <= i_req_row;
            end
         end
      end
   end

   // Product and reported slot are captured where the decision is made.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         prod_q      <= '0;
         done_slot_q <= '0;
      end else begin
         if (state_q == ST_LOOKUP) begin
            prod_q <= PW'(cur_row_q) * PW'(cfg_row_bytes_q);
            if (pad)      done_slot_q <= '0;
            else if (hit) done_slot_q <= hit_slot;
         end
         if (fill) done_slot_q <= wr_ptr;
      end
   end

   assign o_buf_slot = done_slot_q;
   assign o_err      = err_q;
   assign o_dma_addr = cfg_base_q + W_ADDR'(prod_q);
   assign o_dma_len  = cfg_row_bytes_q;
   assign o_dma_slot = wr_ptr;

endmodule

// File: tb/tb_ifm_buf_sched.sv
// Directed bench for ifm_buf_sched: miss, hit, full ring, padding,
// pending/overflow and mid-transfer reset, with hand-computed expectations.
module tb_ifm_buf_sched;

   logic        clk;
   logic        rstn;
   logic        i_start;
   logic [31:0] i_cfg_base;
   logic [15:0] i_cfg_row_bytes;
   logic [11:0] i_cfg_height;
   logic        i_req_load;
   logic [11:0] i_req_row;
   logic        i_release;
   logic        o_buf_done;
   logic [1:0]  o_buf_slot;
   logic        o_busy;
   logic        o_err;
   logic        o_dma_req;
   logic [31:0] o_dma_addr;
   logic [15:0] o_dma_len;
   logic [1:0]  o_dma_slot;
   logic        i_dma_ack;
   logic        i_dma_done;
   logic [3:0]  o_resident;

   int n_checks = 0;
   int n_errs   = 0;

   ifm_buf_sched dut (
      .clk             (clk),
      .rstn            (rstn),
      .i_start         (i_start),
      .i_cfg_base      (i_cfg_base),
      .i_cfg_row_bytes (i_cfg_row_bytes),
      .i_cfg_height    (i_cfg_height),
      .i_req_load      (i_req_load),
      .i_req_row       (i_req_row),
      .i_release       (i_release),
      .o_buf_done      (o_buf_done),
      .o_buf_slot      (o_buf_slot),
      .o_busy          (o_busy),
      .o_err           (o_err),
      .o_dma_req       (o_dma_req),
      .o_dma_addr      (o_dma_addr),
      .o_dma_len       (o_dma_len),
      .o_dma_slot      (o_dma_slot),
      .i_dma_ack       (i_dma_ack),
      .i_dma_done      (i_dma_done),
      .o_resident      (o_resident)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_cfg;
      i_cfg_base      = 32'h1000;
      i_cfg_row_bytes = 16'd2048;
      i_cfg_height    = 12'd256;
      i_start         = 1'b1;
      tick;
      i_start         = 1'b0;
   endtask

   task automatic req(input logic [11:0] row);
      i_req_row  = row;
      i_req_load = 1'b1;
      tick;
      i_req_load = 1'b0;
   endtask

   task automatic rel;
      i_release = 1'b1;
      tick;
      i_release = 1'b0;
   endtask

   task automatic wait_dma(input string tag, input logic [31:0] exp_addr, input logic [1:0] exp_slot);
      int n = 0;
      while (!o_dma_req && n < 8) begin
         tick;
         n++;
      end
      check({tag, "_req"},  o_dma_req,  1);
      check({tag, "_addr"}, o_dma_addr, exp_addr);
      check({tag, "_slot"}, o_dma_slot, exp_slot);
      check({tag, "_len"},  o_dma_len,  16'd2048);
   endtask

   task automatic ack_dma(input string tag);
      i_dma_ack = 1'b1;
      tick;
      i_dma_ack = 1'b0;
      check({tag, "_req_drop"}, o_dma_req, 0);
   endtask

   task automatic done_dma(input string tag, input logic [1:0] exp_slot);
      i_dma_done = 1'b1;
      tick;
      i_dma_done = 1'b0;
      check({tag, "_done"},     o_buf_done, 1);
      check({tag, "_done_slot"}, o_buf_slot, exp_slot);
   endtask

   task automatic miss(input string tag, input logic [11:0] row, input logic [31:0] exp_addr,
                       input logic [1:0] exp_slot);
      req(row);
      wait_dma(tag, exp_addr, exp_slot);
      ack_dma(tag);
      tick;
      done_dma(tag, exp_slot);
      tick;
      check({tag, "_pulse_end"}, o_buf_done, 0);
   endtask

   initial begin
      rstn            = 1'b0;
      i_start         = 1'b0;
      i_cfg_base      = '0;
      i_cfg_row_bytes = '0;
      i_cfg_height    = '0;
      i_req_load      = 1'b0;
      i_req_row       = '0;
      i_release       = 1'b0;
      i_dma_ack       = 1'b0;
      i_dma_done      = 1'b0;
      tick;
      tick;
      check("rst_done",     o_buf_done, 0);
      check("rst_slot",     o_buf_slot, 0);
      check("rst_busy",     o_busy,     0);
      check("rst_err",      o_err,      0);
      check("rst_dma_req",  o_dma_req,  0);
      check("rst_dma_addr", o_dma_addr, 0);
      check("rst_dma_len",  o_dma_len,  0);
      check("rst_resident", o_resident, 0);
      rstn = 1'b1;
      tick;
      start_cfg;

      // Cold miss on row 3, descriptor held for an extra cycle before ack.
      req(12'd3);
      check("cold_lookup_busy", o_busy, 1);
      wait_dma("cold", 32'h2800, 2'd0);
      tick;
      check("cold_hold_req",  o_dma_req,  1);
      check("cold_hold_addr", o_dma_addr, 32'h2800);
      ack_dma("cold");
      tick;
      check("cold_no_early_done", o_buf_done, 0);
      done_dma("cold", 2'd0);
      check("cold_resident", o_resident, 4'b0001);
      tick;
      check("cold_pulse_end", o_buf_done, 0);
      check("cold_idle", o_busy, 0);

      // Hit on row 3: done exactly two cycles after the request.
      req(12'd3);
      check("hit_c1_done", o_buf_done, 0);
      tick;
      check("hit_c2_done", o_buf_done, 1);
      check("hit_c2_slot", o_buf_slot, 0);
      check("hit_no_dma",  o_dma_req,  0);
      tick;
      check("hit_pulse_end", o_buf_done, 0);

      // Fill the ring, then a miss must wait for a release.
      miss("fill0", 12'd0, 32'h1000, 2'd1);
      miss("fill1", 12'd1, 32'h1800, 2'd2);
      miss("fill2", 12'd2, 32'h2000, 2'd3);
      check("ring_full", o_resident, 4'b1111);
      req(12'd4);
      tick;
      check("wfree_busy", o_busy, 1);
      check("wfree_no_dma", o_dma_req, 0);
      tick;
      check("wfree_still_no_dma", o_dma_req, 0);
      rel;
      check("wfree_rel_req",  o_dma_req,  1);
      check("wfree_rel_slot", o_dma_slot, 2'd0);
      check("wfree_rel_addr", o_dma_addr, 32'h3000);
      check("wfree_rel_res",  o_resident, 4'b1110);
      ack_dma("wfree");
      tick;
      done_dma("wfree", 2'd0);
      check("wfree_resident", o_resident, 4'b1111);
      tick;
      rel;
      check("rd_ptr_one", o_resident, 4'b1101);

      // Row 2 now lives in slot 3.
      req(12'd2);
      tick;
      check("hit2_done", o_buf_done, 1);
      check("hit2_slot", o_buf_slot, 2'd3);
      tick;

      // Padding row at the height boundary.
      req(12'd256);
      tick;
      check("pad_done",   o_buf_done, 1);
      check("pad_slot",   o_buf_slot, 0);
      check("pad_no_dma", o_dma_req,  0);
      tick;

      // A misses (row 10), B (row 2, hit) queues, C (row 5) overflows.
      req(12'd10);
      wait_dma("pendA", 32'h6000, 2'd1);
      ack_dma("pendA");
      req(12'd2);
      check("pend_err_clear", o_err, 0);
      req(12'd5);
      check("pend_err_set", o_err, 1);
      done_dma("pendA", 2'd1);
      tick;
      check("pend_gap_done", o_buf_done, 0);
      check("pend_gap_idle", o_busy, 0);
      tick;
      check("pendB_lookup", o_busy, 1);
      tick;
      check("pendB_done", o_buf_done, 1);
      check("pendB_slot", o_buf_slot, 2'd3);
      tick;
      tick;
      tick;
      check("pendC_dropped", o_busy, 0);
      check("pend_err_sticky", o_err, 1);
      start_cfg;
      check("start_err_clr", o_err, 0);
      check("start_res_clr", o_resident, 0);

      // Reset while waiting for the DMA.
      req(12'd7);
      wait_dma("rstw", 32'h4800, 2'd0);
      ack_dma("rstw");
      check("rstw_busy", o_busy, 1);
      rstn = 1'b0;
      tick;
      tick;
      rstn = 1'b1;
      check("rstw_busy_clr", o_busy,     0);
      check("rstw_dma_req",  o_dma_req,  0);
      check("rstw_dma_len",  o_dma_len,  0);
      check("rstw_dma_addr", o_dma_addr, 0);
      check("rstw_resident", o_resident, 0);
      check("rstw_slot",     o_buf_slot, 0);
      tick;
      i_dma_done = 1'b1;
      tick;
      i_dma_done = 1'b0;
      check("rstw_late_done", o_buf_done, 0);
      check("rstw_late_res",  o_resident, 0);
      tick;
      check("rstw_late_busy", o_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
